// File: rtl/pixel_stream_receiver_pkg.sv
// Shared constants and FSM state type for the pixel stream link.
// Also used by the transmitter side.
package pixel_stream_receiver_pkg;

  localparam int PIXELS_PER_PKT = 320;
  localparam int FRAME_PIXELS   = 76800;
  localparam int ADDR_BYTES     = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX_ADDR  = 2'd1,
    RX_PIXEL = 2'd2,
    DRAIN    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/dibit_byte_assembler.sv
// Packs four dibits (LS dibit first) into a byte.
// byte_valid is combinational with the 4th dibit.
module dibit_byte_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       clear,
  output logic [7:0] data_byte,
  output logic       byte_valid
);

  logic [1:0] cnt;
  logic [5:0] sh;

  assign data_byte  = {axiid, sh};
  assign byte_valid = axiiv && !clear && (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear || !axiiv) begin
      cnt <= 2'd0;
      sh  <= 6'd0;
    end else begin
      cnt <= cnt + 2'd1;
      sh  <= {axiid, sh[5:2]};
    end
  end

endmodule

// File: rtl/pixel_stream_receiver.sv
// Receives address + pixel packets over a dibit stream and
// emits frame-buffer writes with wrap-around addressing.
module pixel_stream_receiver
  import pixel_stream_receiver_pkg::*;
#(
  parameter int PIXELS_PER_PKT =
    pixel_stream_receiver_pkg::PIXELS_PER_PKT,
  parameter int FRAME_PIXELS =
    pixel_stream_receiver_pkg::FRAME_PIXELS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic [16:0] pixel_addr,
  output logic [7:0]  pixel_data,
  output logic        pixel_we,
  output logic        line_done,
  output logic        pkt_err
);

  localparam int PW = $clog2(PIXELS_PER_PKT + 1);

  rx_state_e     state;
  logic          prev_v;
  logic          addr_err;
  logic [1:0]    addr_cnt;
  logic [PW-1:0] pix_cnt;
  logic [23:0]   base;
  logic [23:0]   base_nxt;
  logic [16:0]   wr_addr;
  logic          start;
  logic          clear;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  // prev_v is forced high by rst so a packet cut by reset
  // is skipped until axiiv drops.
  assign start    = axiiv && !prev_v;
  assign clear    = (state == DRAIN) ||
                    (state == IDLE && !start);
  assign base_nxt = {base[15:0], rx_byte};

  dibit_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .clear      (clear),
    .data_byte  (rx_byte),
    .byte_valid (byte_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_v     <= 1'b1;
      addr_err   <= 1'b0;
      addr_cnt   <= 2'd0;
      pix_cnt    <= '0;
      base       <= 24'd0;
      wr_addr    <= 17'd0;
      pixel_addr <= 17'd0;
      pixel_data <= 8'd0;
      pixel_we   <= 1'b0;
      line_done  <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      prev_v    <= axiiv;
      pixel_we  <= 1'b0;
      line_done <= 1'b0;
      pkt_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RX_ADDR;
            addr_cnt <= 2'd0;
            pix_cnt  <= '0;
            base     <= 24'd0;
          end
        end
        RX_ADDR: begin
          if (!axiiv) begin
            state   <= IDLE;
            pkt_err <= 1'b1;
          end else if (byte_valid) begin
            base     <= base_nxt;
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'(ADDR_BYTES - 1)) begin
              if (base_nxt < 24'(FRAME_PIXELS)) begin
                state    <= RX_PIXEL;
                addr_err <= 1'b0;
                wr_addr  <= base_nxt[16:0];
              end else begin
                state    <= DRAIN;
                addr_err <= 1'b1;
              end
            end
          end
        end
        RX_PIXEL: begin
          if (!axiiv) begin
            state   <= IDLE;
            pkt_err <= 1'b1;
          end else if (byte_valid) begin
            pixel_we   <= 1'b1;
            pixel_addr <= wr_addr;
            pixel_data <= rx_byte;
            pix_cnt    <= pix_cnt + PW'(1);
            if (wr_addr == 17'(FRAME_PIXELS - 1))
              wr_addr <= 17'd0;
            else
              wr_addr <= wr_addr + 17'd1;
            if (pix_cnt == PW'(PIXELS_PER_PKT - 1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!axiiv) begin
            state     <= IDLE;
            pkt_err   <= addr_err;
            line_done <= !addr_err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Directed bench with a packet-level model and per-cycle
// compare of writes and end-of-packet pulses.
module tb_pixel_stream_receiver;

  localparam int PPP = 320;
  localparam int FP  = 76800;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic [16:0] pixel_addr;
  logic [7:0]  pixel_data;
  logic        pixel_we;
  logic        line_done;
  logic        pkt_err;

  pixel_stream_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .pixel_addr (pixel_addr),
    .pixel_data (pixel_data),
    .pixel_we   (pixel_we),
    .line_done  (line_done),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  wr_t wq[$];
  ev_t eq[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  nwr, nld, nerr;
  int  last_addr, last_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pixel_we) begin
      nwr++;
      last_addr = int'(pixel_addr);
      last_data = int'(pixel_data);
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_write: got addr %0d data %0d expected none",
                 pixel_addr, pixel_data);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", int'(pixel_addr), w.addr);
        chk("wr_data", int'(pixel_data), w.data);
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (line_done || pkt_err) begin
      if (line_done) nld++;
      if (pkt_err) nerr++;
      chk("done_err_exclusive", int'(line_done && pkt_err), 0);
      if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_event: got done=%0d err=%0d expected none",
                 line_done, pkt_err);
      end else begin
        ev_t e;
        e = eq.pop_front();
        chk("event_kind", line_done ? 1 : 2, e.kind);
        chk("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      axiiv = 1'b0;
      axiid = 2'd0;
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_addr"}, int'(pixel_addr), 0);
    chk({name, "_data"}, int'(pixel_data), 0);
    chk({name, "_we"}, int'(pixel_we), 0);
    chk({name, "_done"}, int'(line_done), 0);
    chk({name, "_err"}, int'(pkt_err), 0);
  endtask

  // npix whole pixel bytes, ptail dibits of one more byte,
  // tail trailing dibits; rst pulses with dibit rst_at.
  task automatic send(input int base, input int npix,
                      input int ptail, input int tail,
                      input int rst_at);
    int d[$];
    int b;
    bit aborted;
    bit ok;
    ev_t e;
    aborted = 1'b0;
    ok = (base < FP);
    for (int k = 2; k >= 0; k--) begin
      b = (base >> (8 * k)) & 255;
      for (int s = 0; s < 4; s++) d.push_back((b >> (2 * s)) & 3);
    end
    for (int i = 0; i < npix; i++)
      for (int s = 0; s < 4; s++) d.push_back(((i & 255) >> (2 * s)) & 3);
    for (int s = 0; s < ptail; s++)
      d.push_back(((npix & 255) >> (2 * s)) & 3);
    for (int s = 0; s < tail; s++) d.push_back(int'($urandom_range(0, 3)));
    for (int j = 0; j < d.size(); j++) begin
      @(posedge clk);
      #1;
      if (j == rst_at + 1 && rst_at >= 0) check_zero("post_rst");
      axiiv = 1'b1;
      axiid = 2'(d[j]);
      rst = (j == rst_at);
      if (j == rst_at) aborted = 1'b1;
      if (!aborted && ok && j >= 12 && ((j - 12) % 4) == 3
          && ((j - 12) / 4) < npix && ((j - 12) / 4) < PPP) begin
        wr_t w;
        int i;
        i = (j - 12) / 4;
        w.addr = (base + i) % FP;
        w.data = i & 255;
        w.cyc = cyc + 1;
        wq.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    axiiv = 1'b0;
    axiid = 2'd0;
    if (!aborted) begin
      e.kind = (ok && npix >= PPP) ? 1 : 2;
      e.cyc = cyc + 1;
      eq.push_back(e);
    end
  endtask

  task automatic begin_test();
    nwr = 0;
    nld = 0;
    nerr = 0;
  endtask

  task automatic end_test(input string name, input int ewr,
                          input int eld, input int eerr);
    idle(4);
    chk({name, "_pending_wr"}, wq.size(), 0);
    chk({name, "_pending_ev"}, eq.size(), 0);
    chk({name, "_nwr"}, nwr, ewr);
    chk({name, "_nld"}, nld, eld);
    chk({name, "_nerr"}, nerr, eerr);
  endtask

  initial begin
    rst = 1'b1;
    axiiv = 1'b0;
    axiid = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    begin_test();
    send(0, 320, 0, 16, -1);
    end_test("full", 320, 1, 0);
    chk("full_last_addr", last_addr, 319);
    chk("full_last_data", last_data, 8'h3F);

    begin_test();
    send(76700, 320, 0, 0, -1);
    end_test("wrap", 320, 1, 0);
    chk("wrap_last_addr", last_addr, 219);

    begin_test();
    send(76800, 5, 0, 8, -1);
    end_test("badaddr", 0, 0, 1);

    begin_test();
    send(0, 10, 2, 0, -1);
    end_test("short", 10, 0, 1);
    chk("short_last_addr", last_addr, 9);

    begin_test();
    send(0, 320, 0, 0, -1);
    send(320, 320, 0, 0, -1);
    end_test("b2b", 640, 2, 0);
    chk("b2b_last_addr", last_addr, 639);

    begin_test();
    send(1000, 320, 0, 0, 12 + 5 * 4 + 1);
    end_test("rstmid", 5, 0, 0);
    chk("rstmid_last_addr", last_addr, 1004);
    begin_test();
    send(2000, 320, 0, 4, -1);
    end_test("after_rst", 320, 1, 0);
    chk("after_rst_last_addr", last_addr, 2319);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_stream_receiver.md
PIXEL_STREAM_RECEIVER -- requirements
Module: pixel_stream_receiver

Interface
REQ-001 The block SHALL have parameter PIXELS_PER_PKT, default 320, meaning pixels carried per packet.
REQ-002 The block SHALL have parameter FRAME_PIXELS, default 76800, meaning frame-buffer depth; valid addresses are 0..FRAME_PIXELS-1.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 axiiv  input  1  dibit valid; high for the whole packet, low between packets.
REQ-006 axiid  input  2  received dibit, meaningful only when axiiv=1.
REQ-007 pixel_addr  output  17  frame-buffer write address.
REQ-008 pixel_data  output  8  frame-buffer write data.
REQ-009 pixel_we  output  1  one-cycle write strobe qualifying pixel_addr/pixel_data.
REQ-010 line_done  output  1  one-cycle pulse: packet ended with all PIXELS_PER_PKT pixels written.
REQ-011 pkt_err  output  1  one-cycle pulse: packet ended short, or had a bad address.

Function
REQ-012 Byte assembly SHALL be least-significant dibit first: byte = {d3,d2,d1,d0}, with d0 the first dibit received; each dibit is {axiid[1],axiid[0]}.
REQ-013 The FSM SHALL have states IDLE, RX_ADDR, RX_PIXEL, DRAIN.
REQ-014 IDLE -> RX_ADDR on the first cycle with axiiv=1; that dibit is d0 of address byte 0.
REQ-015 RX_ADDR SHALL take 12 dibits (3 bytes), most-significant byte first, to form a 24-bit base address: byte0 = bits 23:16, byte1 = bits 15:8, byte2 = bits 7:0.
REQ-016 After the 12th dibit: if base < FRAME_PIXELS, go to RX_PIXEL; otherwise go to DRAIN and flag the address error.
REQ-017 In RX_PIXEL, each completed 4-dibit byte is pixel i (i = 0..PIXELS_PER_PKT-1).
REQ-018 Pixel i SHALL be written at address (base+i) mod FRAME_PIXELS; address 76799 is followed by address 0.
REQ-019 pixel_we SHALL assert exactly one cycle after the 4th dibit of a byte is sampled, with pixel_addr/pixel_data valid in that same cycle.
REQ-020 After pixel PIXELS_PER_PKT-1 is written, the FSM SHALL go to DRAIN; trailing dibits (audio segment) SHALL be ignored and SHALL produce no writes.
REQ-021 On axiiv falling while in DRAIN after a full pixel count, line_done SHALL pulse for one cycle in the next cycle, and the FSM returns to IDLE.
REQ-022 On axiiv falling while in DRAIN after an address error, pkt_err SHALL pulse for one cycle and the FSM returns to IDLE.
REQ-023 On axiiv falling in RX_ADDR or RX_PIXEL (including mid-byte), pkt_err SHALL pulse for one cycle and the FSM returns to IDLE.
REQ-024 A short packet's partial byte SHALL be discarded; pixels already written SHALL stay written.
REQ-025 The block SHALL accept a new packet in the cycle immediately after axiiv goes low and then high again, i.e. a one-cycle gap is sufficient.
REQ-026 line_done and pkt_err SHALL never assert in the same cycle.
REQ-027 The block SHALL have no backpressure; the write port is assumed always ready.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE and all counters and the base address SHALL clear to 0.
REQ-029 On rst, pixel_addr=0, pixel_data=0, pixel_we=0, line_done=0, pkt_err=0.
REQ-030 rst SHALL take priority over axiiv.
REQ-031 rst asserted mid-packet SHALL abort the packet with no pkt_err pulse.
REQ-032 After rst releases mid-packet, the remainder of that packet SHALL be ignored until axiiv goes low.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, PIXELS_PER_PKT, FRAME_PIXELS and ADDR_BYTES=3, shared with the transmitter.
REQ-034 Sub-module dibit_byte_assembler SHALL be used: it takes clk, rst, axiiv, axiid and a clear input, and outputs an 8-bit byte plus a one-cycle byte_valid.
REQ-035 The FSM, address counter and pixel counter SHALL live in the top module.

Verification
REQ-036 Full packet: base=0x000000, 320 pixels of value i[7:0], then 16 trailing dibits -> 320 writes at addresses 0..319 with data 0..0xFF,0x00..0x3F; line_done once; no write from trailing dibits.
REQ-037 Wrap: base=76700 -> writes at 76700..76799 then 0..219; line_done once.
REQ-038 Bad address: base=76800 (0x012C00) -> zero writes; pkt_err once after axiiv falls.
REQ-039 Short packet: axiiv drops after 2 dibits of pixel 10 -> writes for pixels 0..9 only; pkt_err once.
REQ-040 Back-to-back: two full packets separated by a 1-cycle axiiv gap, bases 0 and 320 -> 640 writes at 0..639; two line_done pulses.
REQ-041 Reset mid-pixel: rst for 1 cycle during pixel 5 -> outputs 0; no pkt_err; no further writes until the next packet; the next packet is received correctly.
